// File: rtl/serial_addsub_digit.sv
// -----------------------------------------------------------------------------
// serial_addsub_digit
//
// Digit-serial two's-complement adder/subtractor. One DIGIT_W-bit digit pair is
// consumed per valid cycle, least-significant digit first. The result digit is
// registered and appears one cycle after the accepted input digit, with
// valid/last framing that mirrors the input framing. The add/sub mode is taken
// from the first digit of each word. Words that reach MAX_DIGITS digits without
// a last marker are terminated and flagged with out_err.
//
// Optional feature: define SERIAL_ADDSUB_OVF_EN to add the out_ovf port, which
// reports signed overflow of the whole word on the final result digit.
//
// Parameters:
//   DIGIT_W    bits per digit (>= 1)
//   MAX_DIGITS maximum digits per word before forced termination (>= 1)
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   vld       input digit valid
//   a, b      operand digits
//   sub       0 = A+B, 1 = A-B; only looked at on the first digit of a word
//   last      current digit is the most-significant digit (only with vld)
//   out_vld   result digit valid
//   out_sum   result digit
//   out_last  result digit is the final one of the word
//   out_cout  final carry-out (subtract: 1 = no borrow), only with out_last
//   out_err   word was terminated by MAX_DIGITS overrun, only with out_last
//   out_ovf   (SERIAL_ADDSUB_OVF_EN only) signed overflow, only with out_last
// -----------------------------------------------------------------------------
module serial_addsub_digit #(
    parameter int DIGIT_W    = 4,
    parameter int MAX_DIGITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               sub,
    input  logic               last,
    output logic               out_vld,
    output logic [DIGIT_W-1:0] out_sum,
    output logic               out_last,
    output logic               out_cout,
`ifdef SERIAL_ADDSUB_OVF_EN
    output logic               out_ovf,
`endif
    output logic               out_err
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    // Counter value of the digit that must close the word if last is absent.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_DIGITS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic               carry_reg, carry_next;
    logic               mode_reg,  mode_next;
    logic [CNT_W-1:0]   cnt_reg,   cnt_next;

    logic               out_vld_reg,  out_vld_next;
    logic [DIGIT_W-1:0] out_sum_reg,  out_sum_next;
    logic               out_last_reg, out_last_next;
    logic               out_cout_reg, out_cout_next;
    logic               out_err_reg,  out_err_next;
    logic               out_ovf_reg,  out_ovf_next;

    // Digit datapath
    logic               mode_eff;
    logic               carry_in;
    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   sum_full;
    logic               overrun;
    logic               term;
    logic               ovf_digit;

    always_comb begin
        // The first digit of a word takes its mode straight from the port and
        // injects the +1 of the two's-complement negation as carry-in.
        mode_eff = (state_reg == IDLE) ? sub : mode_reg;
        carry_in = (state_reg == IDLE) ? sub : carry_reg;
        b_eff    = mode_eff ? ~b : b;
        sum_full = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, carry_in};
        overrun  = (cnt_reg == CNT_LAST);
        term     = last | overrun;
        // Carry into the MSB is a^b^s at that bit; XOR with carry-out gives
        // signed overflow without a separate narrower adder.
        ovf_digit = a[DIGIT_W-1] ^ b_eff[DIGIT_W-1] ^ sum_full[DIGIT_W-1]
                  ^ sum_full[DIGIT_W];
    end

    always_comb begin
        state_next    = state_reg;
        carry_next    = carry_reg;
        mode_next     = mode_reg;
        cnt_next      = cnt_reg;
        out_vld_next  = 1'b0;
        out_sum_next  = '0;
        out_last_next = 1'b0;
        out_cout_next = 1'b0;
        out_err_next  = 1'b0;
        out_ovf_next  = 1'b0;

        if (vld) begin
            mode_next    = mode_eff;
            out_vld_next = 1'b1;
            out_sum_next = sum_full[DIGIT_W-1:0];
            if (term) begin
                state_next    = IDLE;
                carry_next    = 1'b0;
                cnt_next      = '0;
                out_last_next = 1'b1;
                out_cout_next = sum_full[DIGIT_W];
                // A last on the final permitted digit is a clean end.
                out_err_next  = overrun & ~last;
                out_ovf_next  = ovf_digit;
            end else begin
                state_next = ACTIVE;
                carry_next = sum_full[DIGIT_W];
                cnt_next   = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            carry_reg    <= 1'b0;
            mode_reg     <= 1'b0;
            cnt_reg      <= '0;
            out_vld_reg  <= 1'b0;
            out_sum_reg  <= '0;
            out_last_reg <= 1'b0;
            out_cout_reg <= 1'b0;
            out_err_reg  <= 1'b0;
            out_ovf_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            carry_reg    <= carry_next;
            mode_reg     <= mode_next;
            cnt_reg      <= cnt_next;
            out_vld_reg  <= out_vld_next;
            out_sum_reg  <= out_sum_next;
            out_last_reg <= out_last_next;
            out_cout_reg <= out_cout_next;
            out_err_reg  <= out_err_next;
            out_ovf_reg  <= out_ovf_next;
        end
    end

    assign out_vld  = out_vld_reg;
    assign out_sum  = out_sum_reg;
    assign out_last = out_last_reg;
    assign out_cout = out_cout_reg;
    assign out_err  = out_err_reg;

`ifdef SERIAL_ADDSUB_OVF_EN
    assign out_ovf = out_ovf_reg;
`else
    // Without the port the overflow flop has no load and is trimmed away.
    logic unused_ovf;
    assign unused_ovf = out_ovf_reg;
`endif

endmodule

// File: tb/tb_serial_addsub_digit.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub_digit
//
// Directed and randomized bench for serial_addsub_digit with DIGIT_W=4 and
// MAX_DIGITS=4. Random words are checked against a word-level integer model:
// the whole operands are assembled, added/subtracted as integers, and the
// result is sliced back into digits, carry-out and signed-overflow flags.
// -----------------------------------------------------------------------------
module tb_serial_addsub_digit;

    localparam int DW   = 4;
    localparam int MAXD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sub;
    logic          last;
    logic          out_vld;
    logic [DW-1:0] out_sum;
    logic          out_last;
    logic          out_cout;
    logic          out_err;
    logic          ovf_obs;

    int checks = 0;
    int errors = 0;

    serial_addsub_digit #(
        .DIGIT_W   (DW),
        .MAX_DIGITS(MAXD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .vld     (vld),
        .a       (a),
        .b       (b),
        .sub     (sub),
        .last    (last),
        .out_vld (out_vld),
        .out_sum (out_sum),
        .out_last(out_last),
        .out_cout(out_cout),
`ifdef SERIAL_ADDSUB_OVF_EN
        .out_ovf (ovf_obs),
`endif
        .out_err (out_err)
    );

`ifndef SERIAL_ADDSUB_OVF_EN
    assign ovf_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    // Compare the registered outputs (sampled 1 time unit after the edge)
    // against the expected tuple. Overflow is only compared when the port
    // exists.
    task automatic check_out(input logic ev, input logic [DW-1:0] es,
                             input logic el, input logic ec, input logic ee,
                             input logic eo, input string tag);
        logic [DW+4:0] obs;
        logic [DW+4:0] exp;
`ifdef SERIAL_ADDSUB_OVF_EN
        exp = {ev, es, el, ec, ee, eo};
`else
        exp = {ev, es, el, ec, ee, 1'b0};
`endif
        obs = {out_vld, out_sum, out_last, out_cout, out_err, ovf_obs};
        checks++;
        $display("txn %-10s vld=%0b a=%h b=%h sub=%0b last=%0b rst=%0b -> out(vld,sum,last,cout,err,ovf)=%b exp=%b",
                 tag, vld, a, b, sub, last, rst, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, step past the edge, check outputs.
    task automatic cyc(input logic v, input logic [DW-1:0] ia, input logic [DW-1:0] ib,
                       input logic is, input logic il,
                       input logic ev, input logic [DW-1:0] es, input logic el,
                       input logic ec, input logic ee, input logic eo,
                       input string tag);
        vld  = v;
        a    = ia;
        b    = ib;
        sub  = is;
        last = il;
        @(posedge clk);
        #1;
        check_out(ev, es, el, ec, ee, eo, tag);
    endtask

    // Idle cycle with random junk on the data/control lines.
    task automatic idle(input string tag);
        cyc(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    // Reset cycle: inputs presented during reset are discarded.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        cyc(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 1'b1,
            1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
        rst = 1'b0;
    endtask

    // Random word of n digits. With overrun set, n must equal MAXD and no
    // last is given; the DUT must close the word itself.
    task automatic rand_word(input int n, input bit overrun, input int gap_max);
        logic [DW-1:0] da[MAXD];
        logic [DW-1:0] db[MAXD];
        bit     s;
        longint mask, half, A, B, X, R, sa, sx, tot;
        bit     cout, ovf;
        mask = (longint'(1) << (DW * n)) - 1;
        half = longint'(1) << (DW * n - 1);
        s = 1'($urandom);
        A = 0;
        B = 0;
        for (int i = 0; i < n; i++) begin
            da[i] = 4'($urandom);
            db[i] = 4'($urandom);
            A = A | (longint'(da[i]) << (DW * i));
            B = B | (longint'(db[i]) << (DW * i));
        end
        X    = s ? (~B & mask) : B;
        R    = A + X + longint'(s);
        cout = ((R >> (DW * n)) & 1) != 0;
        sa   = (A >= half) ? A - (mask + 1) : A;
        sx   = (X >= half) ? X - (mask + 1) : X;
        tot  = sa + sx + longint'(s);
        ovf  = (tot > half - 1) || (tot < -half);
        for (int i = 0; i < n; i++) begin
            bit fin;
            repeat ($urandom_range(0, gap_max)) idle("rnd_gap");
            fin = (i == n - 1);
            cyc(1'b1, da[i], db[i], (i == 0) ? s : 1'($urandom), fin && !overrun,
                1'b1, 4'((R >> (DW * i)) & 64'hF), fin, fin && cout,
                fin && overrun, fin && ovf, "rnd");
        end
    endtask

    initial begin
        rst  = 1'b1;
        vld  = 1'b0;
        a    = '0;
        b    = '0;
        sub  = 1'b0;
        last = 1'b0;

        // Reset values, including discarding a valid digit held during reset.
        do_reset("rst0");
        do_reset("rst1");
        idle("post_rst");

        // 0x1234 + 0x0FFF = 0x2233, last on the 4th (= MAX) digit -> no err.
        cyc(1, 4'h4, 4'hF, 0, 0, 1, 4'h3, 0, 0, 0, 0, "add_d0");
        cyc(1, 4'h3, 4'hF, 0, 0, 1, 4'h3, 0, 0, 0, 0, "add_d1");
        cyc(1, 4'h2, 4'hF, 0, 0, 1, 4'h2, 0, 0, 0, 0, "add_d2");
        cyc(1, 4'h1, 4'h0, 0, 1, 1, 4'h2, 1, 0, 0, 0, "add_d3");

        // 0x05 - 0x07 = 0xFE with borrow (cout=0).
        cyc(1, 4'h5, 4'h7, 1, 0, 1, 4'hE, 0, 0, 0, 0, "sub_d0");
        cyc(1, 4'h0, 4'h0, 0, 1, 1, 4'hF, 1, 0, 0, 0, "sub_d1");

        // Same add with idle gaps, last pulsed while idle, sub toggled mid-word.
        cyc(1, 4'h4, 4'hF, 0, 0, 1, 4'h3, 0, 0, 0, 0, "gap_d0");
        cyc(0, 4'h0, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0, 0, "gap_i0");
        cyc(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, "gap_i1");
        cyc(1, 4'h3, 4'hF, 1, 0, 1, 4'h3, 0, 0, 0, 0, "gap_d1");
        idle("gap_i2");
        cyc(0, 4'h9, 4'h9, 1, 1, 0, 4'h0, 0, 0, 0, 0, "gap_i3");
        cyc(1, 4'h2, 4'hF, 1, 0, 1, 4'h2, 0, 0, 0, 0, "gap_d2");
        idle("gap_i4");
        idle("gap_i5");
        cyc(1, 4'h1, 4'h0, 0, 1, 1, 4'h2, 1, 0, 0, 0, "gap_d3");

        // Overrun: 5 digits 1+0 with no last. 4th closes the word with err;
        // 5th opens a new word.
        cyc(1, 4'h1, 4'h0, 0, 0, 1, 4'h1, 0, 0, 0, 0, "ovr_d0");
        cyc(1, 4'h1, 4'h0, 0, 0, 1, 4'h1, 0, 0, 0, 0, "ovr_d1");
        cyc(1, 4'h1, 4'h0, 0, 0, 1, 4'h1, 0, 0, 0, 0, "ovr_d2");
        cyc(1, 4'h1, 4'h0, 0, 0, 1, 4'h1, 1, 0, 1, 0, "ovr_d3");
        cyc(1, 4'h1, 4'h0, 0, 0, 1, 4'h1, 0, 0, 0, 0, "ovr_d4");

        // Second digit of that word, then reset drops it without out_last.
        cyc(1, 4'h1, 4'h0, 0, 0, 1, 4'h1, 0, 0, 0, 0, "drop_d1");
        do_reset("rst_mid");

        // Single-digit words after the reset.
        cyc(1, 4'hF, 4'h1, 0, 1, 1, 4'h0, 1, 1, 0, 0, "f_plus_1");
        cyc(1, 4'h7, 4'h1, 0, 1, 1, 4'h8, 1, 0, 0, 1, "7_plus_1");

        // Back-to-back single-digit words: 2+3 then 3-2.
        cyc(1, 4'h2, 4'h3, 0, 1, 1, 4'h5, 1, 0, 0, 0, "b2b_add");
        cyc(1, 4'h3, 4'h2, 1, 1, 1, 4'h1, 1, 1, 0, 0, "b2b_sub");
        // Signed overflow on subtract: 0x8 - 0x1 = 0x7 (-8-1 overflows).
        cyc(1, 4'h8, 4'h1, 1, 1, 1, 4'h7, 1, 1, 0, 1, "sub_ovf");
        idle("idle_end");

        // Randomized words against the word-level model.
        for (int w = 0; w < 60; w++) begin
            if ($urandom_range(0, 4) == 0) rand_word(MAXD, 1'b1, 2);
            else rand_word(int'($urandom_range(1, MAXD)), 1'b0, 2);
        end
        idle("idle_tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion before 200000");
        $fatal(1, "timeout");
    end

endmodule
